// File: rtl/zero_detect_pipe_if.sv
// zero_detect_pipe_if
// Purpose: bundles the request and result signals of zero_detect_pipe.
// Signals:
//   i_valid      request present on i_mode/i_a/i_b this cycle
//   i_stall      hold pipeline and status registers
//   i_flush      drop all in-flight requests
//   i_mode       00 zero, 01 ones, 10 sign, 11 equal
//   i_a, i_b     operands (i_b used by equal mode only)
//   i_sticky_clr clear o_sticky and o_hit_cnt
//   o_valid      o_flag holds a valid result
//   o_flag       result of the selected test
//   o_sticky     a valid result with flag=1 has been seen
//   o_hit_cnt    saturating count of valid results with flag=1
// Modports: master drives requests, slave is the detector.
interface zero_detect_pipe_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             i_valid;
  logic             i_stall;
  logic             i_flush;
  logic [1:0]       i_mode;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_sticky_clr;
  logic             o_valid;
  logic             o_flag;
  logic             o_sticky;
  logic [CNT_W-1:0] o_hit_cnt;

  modport master (
    output i_valid, i_stall, i_flush, i_mode, i_a, i_b, i_sticky_clr,
    input  o_valid, o_flag, o_sticky, o_hit_cnt
  );

  modport slave (
    input  i_valid, i_stall, i_flush, i_mode, i_a, i_b, i_sticky_clr,
    output o_valid, o_flag, o_sticky, o_hit_cnt
  );
endinterface

// File: rtl/zero_detect_pipe.sv
// zero_detect_pipe
// Purpose: two-stage pipelined operand test (zero / all-ones / sign / equal)
// with a sticky hit flag and a saturating hit counter.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  asynchronous active-high reset
//   io     zero_detect_pipe_if.slave (requests in, results and status out)
// Parameters:
//   WIDTH  operand width (4..128)
//   GROUP  operand bits per first-level OR node (2..8)
//   CNT_W  hit counter width (2..16)
module zero_detect_pipe #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4,
  parameter int CNT_W = 8
) (
  input logic             i_clk,
  input logic             i_rst,
  zero_detect_pipe_if.slave io
);

  localparam int NG = (WIDTH + GROUP - 1) / GROUP;
  localparam int PW = NG * GROUP;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PW-1:0]    w_tvec;
  logic [NG-1:0]    w_grp;
  logic             w_flag_next;
  logic             w_adv;
  logic             w_hit;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_next;

  logic             r_s1_valid;
  logic [1:0]       r_s1_mode;
  logic             r_s1_msb;
  logic [NG-1:0]    r_s1_grp;
  logic             r_s2_valid;
  logic             r_flag;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;

  // Test vector: every mode except sign reduces to "vector is all zero".
  // Pad bits above WIDTH stay 0 so they can never mask or fake a hit.
  always_comb begin
    w_tvec = '0;
    case (io.i_mode)
      2'b00:   w_tvec[WIDTH-1:0] = io.i_a;
      2'b01:   w_tvec[WIDTH-1:0] = ~io.i_a;
      2'b11:   w_tvec[WIDTH-1:0] = io.i_a ^ io.i_b;
      default: w_tvec = '0;
    endcase
  end

  for (genvar k = 0; k < NG; k++) begin : g_grp
    assign w_grp[k] = |w_tvec[k*GROUP +: GROUP];
  end

  // Stage-1 data carries no reset; only the valid bit qualifies it.
  always_ff @(posedge i_clk) begin
    if (!io.i_stall) begin
      r_s1_grp  <= w_grp;
      r_s1_mode <= io.i_mode;
      r_s1_msb  <= io.i_a[WIDTH-1];
    end
  end

  // Final reduction works only from stage-1 registers.
  assign w_flag_next = (r_s1_mode == 2'b10) ? r_s1_msb : ~(|r_s1_grp);
  assign w_adv       = !io.i_flush && !io.i_stall;
  assign w_hit       = w_adv && r_s1_valid && w_flag_next;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_flag     <= 1'b0;
    end else if (io.i_flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (!io.i_stall) begin
      r_s1_valid <= io.i_valid;
      r_s2_valid <= r_s1_valid;
      // flag only changes when a real result arrives; bubbles keep the old one
      if (r_s1_valid) begin
        r_flag <= w_flag_next;
      end
    end
  end

  // A clear and a hit on the same edge: the clear lands first, then the hit.
  always_comb begin
    w_cnt_base = io.i_sticky_clr ? '0 : r_cnt;
    w_cnt_next = w_cnt_base;
    if (w_hit && (w_cnt_base != CNT_MAX)) begin
      w_cnt_next = w_cnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (!io.i_stall) begin
      r_sticky <= (r_sticky && !io.i_sticky_clr) || w_hit;
      r_cnt    <= w_cnt_next;
    end
  end

  assign io.o_valid   = r_s2_valid;
  assign io.o_flag    = r_flag;
  assign io.o_sticky  = r_sticky;
  assign io.o_hit_cnt = r_cnt;

endmodule

// File: tb/tb_zero_detect_pipe.sv
// tb_zero_detect_pipe
// Purpose: self-checking bench for zero_detect_pipe. Three instances cover
// the default build, a 2-bit counter build and a 10-bit/GROUP=4 build.
// Expected results are queued with the advancing edge they are due on and
// popped when the selected instance presents a result.
module tb_zero_detect_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, flush, sticky_clr;
  logic [1:0]  mode;
  logic [31:0] a, b;
  int          sel;

  always #5 clk = ~clk;

  zero_detect_pipe_if #(.WIDTH(32), .CNT_W(8)) if0 ();
  zero_detect_pipe_if #(.WIDTH(32), .CNT_W(2)) if1 ();
  zero_detect_pipe_if #(.WIDTH(10), .CNT_W(8)) if2 ();

  assign if0.i_valid = in_valid && (sel == 0);
  assign if1.i_valid = in_valid && (sel == 1);
  assign if2.i_valid = in_valid && (sel == 2);
  assign if0.i_stall = stall;
  assign if1.i_stall = stall;
  assign if2.i_stall = stall;
  assign if0.i_flush = flush;
  assign if1.i_flush = flush;
  assign if2.i_flush = flush;
  assign if0.i_sticky_clr = sticky_clr;
  assign if1.i_sticky_clr = sticky_clr;
  assign if2.i_sticky_clr = sticky_clr;
  assign if0.i_mode = mode;
  assign if1.i_mode = mode;
  assign if2.i_mode = mode;
  assign if0.i_a = a;
  assign if1.i_a = a;
  assign if2.i_a = a[9:0];
  assign if0.i_b = b;
  assign if1.i_b = b;
  assign if2.i_b = b[9:0];

  zero_detect_pipe #(.WIDTH(32), .GROUP(4), .CNT_W(8)) u_dut0 (.i_clk(clk), .i_rst(rst), .io(if0));
  zero_detect_pipe #(.WIDTH(32), .GROUP(4), .CNT_W(2)) u_dut1 (.i_clk(clk), .i_rst(rst), .io(if1));
  zero_detect_pipe #(.WIDTH(10), .GROUP(4), .CNT_W(8)) u_dut2 (.i_clk(clk), .i_rst(rst), .io(if2));

  logic        o_valid, o_flag, o_sticky;
  logic [15:0] o_cnt;

  always_comb begin
    o_valid  = if0.o_valid;
    o_flag   = if0.o_flag;
    o_sticky = if0.o_sticky;
    o_cnt    = 16'(if0.o_hit_cnt);
    case (sel)
      1: begin
        o_valid = if1.o_valid; o_flag = if1.o_flag;
        o_sticky = if1.o_sticky; o_cnt = 16'(if1.o_hit_cnt);
      end
      2: begin
        o_valid = if2.o_valid; o_flag = if2.o_flag;
        o_sticky = if2.o_sticky; o_cnt = 16'(if2.o_hit_cnt);
      end
      default: ;
    endcase
  end

  typedef struct {
    bit flag;
    int due;
  } exp_t;

  typedef struct {
    int          sel;
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    bit          exp;
  } vec_t;

  exp_t q[$];
  vec_t tbl[20];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_n = 0;
  int   exp_cnt = 0;
  int   cnt_max = 255;
  bit   exp_sticky = 1'b0;
  bit   pend_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", name, act, exp, $time, sel);
    end
  endtask

  // Independent reference for one request on a w-bit operand.
  function automatic bit model_flag(input int w, input logic [1:0] m,
                                    input logic [31:0] x, input logic [31:0] y);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case (m)
      2'b00:   return (x & mask) == 32'd0;
      2'b01:   return (x & mask) == mask;
      2'b10:   return x[w-1];
      default: return ((x ^ y) & mask) == 32'd0;
    endcase
  endfunction

  task automatic step();
    bit   adv, was_stall, was_flush, clr, due;
    logic pv, pf;
    exp_t e;
    adv       = !stall && !flush;
    was_stall = stall;
    was_flush = flush;
    clr       = sticky_clr;
    pv        = o_valid;
    pf        = o_flag;
    @(posedge clk);
    if (adv) edge_n++;
    #1;
    if (was_flush) begin
      q.delete();
      if (!was_stall && clr) begin exp_cnt = 0; exp_sticky = 1'b0; end
      chk("flush_valid", 32'(o_valid), 32'd0);
      chk("flush_flag_hold", 32'(o_flag), 32'(pf));
    end else if (was_stall) begin
      chk("stall_valid_hold", 32'(o_valid), 32'(pv));
      chk("stall_flag_hold", 32'(o_flag), 32'(pf));
    end else begin
      due = (q.size() > 0) && (q[0].due == edge_n);
      if (clr) begin exp_cnt = 0; exp_sticky = 1'b0; end
      chk("out_valid", 32'(o_valid), 32'(due));
      if (due) begin
        e = q.pop_front();
        chk("flag", 32'(o_flag), 32'(e.flag));
        if (e.flag) begin
          exp_sticky = 1'b1;
          if (exp_cnt < cnt_max) exp_cnt++;
        end
      end
      if (in_valid) q.push_back('{flag: pend_exp, due: edge_n + 1});
    end
    chk("sticky", 32'(o_sticky), 32'(exp_sticky));
    chk("hit_cnt", 32'(o_cnt), 32'(exp_cnt));
  endtask

  task automatic req(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y, input bit e);
    in_valid = 1'b1; mode = m; a = x; b = y; pend_exp = e;
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_sel(input int s);
    sel = s;
    cnt_max = (s == 1) ? 3 : 255;
    in_valid = 1'b0;
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{0, 2'b00, 32'h0000_0000, 32'h0, 1'b1};
    tbl[1]  = '{0, 2'b00, 32'h0001_0000, 32'h0, 1'b0};
    tbl[2]  = '{0, 2'b01, 32'hFFFF_FFFF, 32'h0, 1'b1};
    tbl[3]  = '{0, 2'b01, 32'hFFFF_FFFE, 32'h0, 1'b0};
    tbl[4]  = '{0, 2'b10, 32'h8000_0000, 32'h0, 1'b1};
    tbl[5]  = '{0, 2'b10, 32'h7FFF_FFFF, 32'h0, 1'b0};
    tbl[6]  = '{0, 2'b11, 32'h1234_ABCD, 32'h1234_ABCD, 1'b1};
    tbl[7]  = '{0, 2'b11, 32'h1234_ABCD, 32'h1234_ABCC, 1'b0};
    tbl[8]  = '{0, 2'b00, 32'h0000_0001, 32'h0, 1'b0};
    tbl[9]  = '{0, 2'b01, 32'h7FFF_FFFF, 32'h0, 1'b0};
    tbl[10] = '{0, 2'b11, 32'h0000_0000, 32'h0, 1'b1};
    tbl[11] = '{0, 2'b00, 32'h8000_0000, 32'h0, 1'b0};
    tbl[12] = '{2, 2'b00, 32'h0000_0000, 32'h0, 1'b1};
    tbl[13] = '{2, 2'b01, 32'h0000_03FF, 32'h0, 1'b1};
    tbl[14] = '{2, 2'b00, 32'h0000_0200, 32'h0, 1'b0};
    tbl[15] = '{2, 2'b01, 32'h0000_01FF, 32'h0, 1'b0};
    tbl[16] = '{2, 2'b11, 32'h0000_02AA, 32'h2AA, 1'b1};
    tbl[17] = '{2, 2'b11, 32'h0000_0155, 32'h154, 1'b0};
    tbl[18] = '{2, 2'b10, 32'h0000_0200, 32'h0, 1'b1};
    tbl[19] = '{2, 2'b10, 32'h0000_01FF, 32'h0, 1'b0};

    sel = 0; rst = 1'b1;
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0; sticky_clr = 1'b0;
    mode = 2'b00; a = '0; b = '0;
    #12;
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_flag", 32'(o_flag), 32'd0);
    chk("reset_sticky", 32'(o_sticky), 32'd0);
    chk("reset_cnt", 32'(o_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back table vectors per instance
    for (int i = 0; i < 20; i++) begin
      if (tbl[i].sel != sel) begin
        idle(3);
        set_sel(tbl[i].sel);
      end
      req(tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].exp);
    end
    idle(3);

    // Stall mid-stream, then flush together with stall
    set_sel(0);
    req(2'b00, 32'h0, 32'h0, 1'b1);
    req(2'b00, 32'h5, 32'h0, 1'b0);
    stall = 1'b1;
    a = 32'h0;
    step();
    step();
    stall = 1'b0;
    req(2'b01, 32'hFFFF_FFFF, 32'h0, model_flag(32, 2'b01, 32'hFFFF_FFFF, 32'h0));
    idle(3);
    chk("stall_order_cnt", 32'(o_cnt), 32'd2);
    req(2'b00, 32'h0, 32'h0, 1'b1);
    req(2'b10, 32'h8000_0000, 32'h0, 1'b1);
    stall = 1'b1; flush = 1'b1;
    step();
    chk("flush_sticky_kept", 32'(o_sticky), 32'd1);
    stall = 1'b0; flush = 1'b0;
    idle(3);

    // Saturation and clear-with-hit on the 2-bit counter
    set_sel(1);
    for (int i = 0; i < 5; i++) req(2'b00, 32'h0, 32'h0, 1'b1);
    idle(3);
    chk("sat_cnt", 32'(o_cnt), 32'd3);
    req(2'b00, 32'h0, 32'h0, 1'b1);
    in_valid = 1'b0;
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("clr_hit_sticky", 32'(o_sticky), 32'd1);
    chk("clr_hit_cnt", 32'(o_cnt), 32'd1);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("clr_only_sticky", 32'(o_sticky), 32'd0);
    chk("clr_only_cnt", 32'(o_cnt), 32'd0);
    idle(2);

    // Asynchronous reset with two requests in flight
    set_sel(0);
    req(2'b00, 32'h0, 32'h0, 1'b1);
    req(2'b11, 32'h7, 32'h7, 1'b1);
    in_valid = 1'b0;
    chk("pre_reset_valid", 32'(o_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("areset_valid", 32'(o_valid), 32'd0);
    chk("areset_flag", 32'(o_flag), 32'd0);
    chk("areset_sticky", 32'(o_sticky), 32'd0);
    chk("areset_cnt", 32'(o_cnt), 32'd0);
    q.delete();
    exp_cnt = 0; exp_sticky = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    req(2'b00, 32'h0, 32'h0, 1'b1);
    idle(3);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/zero_detect_pipe.md
ZERO_DETECT_PIPE -- requirements
Module: zero_detect_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; legal range 4..128.
REQ-002 Parameter GROUP, default 4: operand bits per first-level OR node; legal range 2..8.
REQ-003 Parameter CNT_W, default 8: width of the saturating hit counter; legal range 2..16.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  a, b and mode carry a request this cycle.
REQ-007 stall  input  1  hold all pipeline and status registers.
REQ-008 flush  input  1  discard all in-flight requests.
REQ-009 mode  input  2  00 zero (a==0); 01 ones (a all 1s); 10 sign (a[WIDTH-1]==1); 11 equal (a==b).
REQ-010 a  input  WIDTH  primary operand.
REQ-011 b  input  WIDTH  compare operand; used only in mode 11.
REQ-012 sticky_clr  input  1  clear sticky and hit_cnt.
REQ-013 out_valid  output  1  flag holds a valid result.
REQ-014 flag  output  1  result of the selected test, 1 = condition true.
REQ-015 sticky  output  1  set once any valid result with flag=1 has been produced.
REQ-016 hit_cnt  output  CNT_W  saturating count of valid results with flag=1.

Function
REQ-017 Pipeline is two register stages; a request accepted on edge N appears on out_valid/flag after edge N+1 (latency 2 cycles, throughput 1 per cycle).
REQ-018 Stage 1 registers: valid bit, mode, MSB of a, and NG=ceil(WIDTH/GROUP) group bits; group k = OR of its GROUP bits of the test vector.
REQ-019 Test vector: a in mode 00; ~a in mode 01; a^b in mode 11; don't-care in mode 10.
REQ-020 When WIDTH is not a multiple of GROUP, pad bits of the top group are 0 in the test vector, so padding never affects any mode.
REQ-021 Stage 2 registers: out_valid and flag = NOR of all NG group bits in modes 00/01/11, and = stored MSB in mode 10.
REQ-022 Stage-2 flag is computed only from stage-1 registers; no operand bit reaches flag combinationally.
REQ-023 in_valid=0 loads a bubble into stage 1 (valid=0); stage-1 data may take any value.
REQ-024 stall=1 (flush=0): both stages, sticky and hit_cnt hold; in_valid is ignored that cycle.
REQ-025 flush=1: both stage valid bits clear on that edge regardless of stall or in_valid; flag holds its previous value; sticky and hit_cnt are unaffected.
REQ-026 Precedence on one edge: reset > flush > stall > normal advance.
REQ-027 sticky/hit_cnt update on the edge where stage 2 loads a valid result with flag=1: sticky<=1, hit_cnt<=hit_cnt+1.
REQ-028 hit_cnt saturates at 2^CNT_W-1 and never wraps.
REQ-029 sticky_clr=1 with no simultaneous hit: sticky<=0, hit_cnt<=0.
REQ-030 sticky_clr=1 with a simultaneous hit: clear applies first, then the hit, so sticky<=1 and hit_cnt<=1.
REQ-031 sticky_clr is ignored while stall=1.
REQ-032 out_valid deasserted: flag holds its last value; consumers ignore it.

Reset
REQ-033 reset=1 asynchronously forces both stage valid bits, out_valid, flag, sticky and hit_cnt to 0 without waiting for a clock edge.
REQ-034 Stage-1 data registers (group bits, mode, MSB) are not reset.
REQ-035 reset asserted mid-operation drops all in-flight requests; the first request after reset release behaves as in REQ-017.

Verification
REQ-036 Defaults, mode 00: a=0x00000000, then a=0x00010000 on successive cycles -> after 2 cycles, flag=1 then flag=0, out_valid high both cycles, hit_cnt=1.
REQ-037 Modes 01/10/11: a=0xFFFFFFFF mode 01 -> flag=1; a=0x80000000 mode 10 -> flag=1; a=b=0x1234ABCD mode 11 -> flag=1; same a with b=0x1234ABCC -> flag=0.
REQ-038 Stall/flush: inject 3 back-to-back requests, stall=1 for 2 cycles mid-stream -> outputs frozen, order preserved; flush=1 together with stall=1 -> out_valid=0 next cycle, sticky unchanged.
REQ-039 Saturation/clear: CNT_W=2, 5 consecutive zero hits -> hit_cnt=3 and holds; sticky_clr on the cycle of a 6th hit -> sticky=1, hit_cnt=1.
REQ-040 Width padding: WIDTH=10, GROUP=4, a=0x000 mode 00 -> flag=1; a=0x3FF mode 01 -> flag=1; a=0x200 mode 00 -> flag=0.
REQ-041 Async reset: assert reset between clock edges with 2 requests in flight -> out_valid, flag, sticky, hit_cnt = 0 immediately; no result emerges after release.
